// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer sitting between dispatch/LSU execute and
// data memory. Stores take a slot at dispatch, get operands at execute, are
// committed by the ROB in order, then drained to memory through req/ack.
// Uncommitted stores are squashed on mispredict using the ROB flush mask.
//
// Build option: define STORE_FWD_EN to enable store-to-load forwarding.
// Without it, any word-address hit on an executed store only stalls the load.
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [ROB_IDX_W-1:0]       alloc_rob_idx,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_sb_idx,
    input  logic                       ex_valid,
    input  logic [$clog2(DEPTH)-1:0]   ex_sb_idx,
    input  logic [31:0]                ex_addr,
    input  logic [31:0]                ex_data,
    input  logic [3:0]                 ex_strb,
    input  logic                       st_commit,
    input  logic                       mispredict,
    input  logic [(2**ROB_IDX_W)-1:0]  flush_mask,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_strb,
    input  logic                       mem_ack,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    input  logic [3:0]                 ld_strb,
    output logic                       fwd_hit,
    output logic [31:0]                fwd_data,
    output logic                       fwd_stall,
    output logic                       empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Per-slot storage
    logic                 r_valid [DEPTH];
    logic                 r_exec  [DEPTH];
    logic                 r_comm  [DEPTH];
    logic [ROB_IDX_W-1:0] r_rob   [DEPTH];
    logic [31:0]          r_addr  [DEPTH];
    logic [31:0]          r_data  [DEPTH];
    logic [3:0]           r_strb  [DEPTH];

    // Pointers carry a wrap bit above the slot index
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_cptr;
    logic [PTR_W-1:0] r_tail;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_cptr_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_full;
    logic             w_alloc_fire;
    logic             w_commit_fire;
    logic             w_drain;
    logic [PTR_W-1:0] w_cptr_eff;
    logic [PTR_W-1:0] w_unc_cnt;
    logic [IDX_W-1:0] w_off [DEPTH];
    logic [DEPTH-1:0] w_in_scan;
    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_kill;
    logic             w_flush_hit;
    logic [IDX_W-1:0] w_flush_off;
    logic             w_flush_take;
    logic [PTR_W-1:0] w_tail_next;
    logic             w_unused_bits;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_cptr_idx = r_cptr[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];

    assign w_full      = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign empty       = (r_head == r_tail);
    assign alloc_ready = !w_full;
    assign alloc_sb_idx = w_tail_idx;

    // A mispredict suppresses allocation in the same cycle
    assign w_alloc_fire  = alloc_valid && alloc_ready && !mispredict;
    assign w_commit_fire = st_commit && (r_cptr != r_tail);

    // Drain straight from the head slot; fields stay put until acked
    assign mem_req   = r_valid[w_head_idx] && r_comm[w_head_idx] && r_exec[w_head_idx];
    assign mem_addr  = r_addr[w_head_idx];
    assign mem_wdata = r_data[w_head_idx];
    assign mem_strb  = r_strb[w_head_idx];
    assign w_drain   = mem_req && mem_ack;

    // Commit lands before the flush scan, so the scan starts past it
    assign w_cptr_eff = r_cptr + PTR_W'(w_commit_fire);
    assign w_unc_cnt  = r_tail - w_cptr_eff;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_scan
            // Distance of this slot from the first flushable slot
            assign w_off[gi]     = IDX_W'(gi) - w_cptr_eff[IDX_W-1:0];
            assign w_in_scan[gi] = ({1'b0, w_off[gi]} < w_unc_cnt);
            assign w_match[gi]   = w_in_scan[gi] && r_valid[gi] && !r_comm[gi]
                                   && flush_mask[r_rob[gi]];
            assign w_kill[gi]    = w_flush_take && w_in_scan[gi] && (w_off[gi] >= w_flush_off);
        end
    endgenerate

    // Oldest squashed store in the uncommitted region sets the new tail
    always_comb begin
        w_flush_hit = 1'b0;
        w_flush_off = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (w_match[s] && (!w_flush_hit || (w_off[s] < w_flush_off))) begin
                w_flush_hit = 1'b1;
                w_flush_off = w_off[s];
            end
        end
    end

    assign w_flush_take = mispredict && w_flush_hit;
    assign w_tail_next  = w_flush_take ? (w_cptr_eff + PTR_W'(w_flush_off))
                                       : (r_tail + PTR_W'(w_alloc_fire));

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_cptr <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_drain);
            r_cptr <= w_cptr_eff;
            r_tail <= w_tail_next;
        end
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Slot state: drain and squash clear it; alloc, execute and commit fill it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_exec[gi]  <= 1'b0;
                    r_comm[gi]  <= 1'b0;
                    r_rob[gi]   <= '0;
                    r_addr[gi]  <= '0;
                    r_data[gi]  <= '0;
                    r_strb[gi]  <= '0;
                end else if ((w_drain && (w_head_idx == IDX_W'(gi))) || w_kill[gi]) begin
                    r_valid[gi] <= 1'b0;
                    r_exec[gi]  <= 1'b0;
                    r_comm[gi]  <= 1'b0;
                    r_rob[gi]   <= '0;
                    r_addr[gi]  <= '0;
                    r_data[gi]  <= '0;
                    r_strb[gi]  <= '0;
                end else begin
                    if (w_alloc_fire && (w_tail_idx == IDX_W'(gi))) begin
                        r_valid[gi] <= 1'b1;
                        r_exec[gi]  <= 1'b0;
                        r_comm[gi]  <= 1'b0;
                        r_rob[gi]   <= alloc_rob_idx;
                    end
                    if (ex_valid && (ex_sb_idx == IDX_W'(gi)) && r_valid[gi]) begin
                        r_exec[gi] <= 1'b1;
                        r_addr[gi] <= ex_addr;
                        r_data[gi] <= ex_data;
                        r_strb[gi] <= ex_strb;
                    end
                    if (w_commit_fire && (w_cptr_idx == IDX_W'(gi))) begin
                        r_comm[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Word-address hit against executed stores
    logic [DEPTH-1:0] w_word_match;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            assign w_word_match[gi] = r_valid[gi] && r_exec[gi]
                                      && (r_addr[gi][31:2] == ld_addr[31:2]);
        end
    endgenerate

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] w_fwd_cand;
    logic [IDX_W-1:0] w_age [DEPTH];
    logic             w_fwd_found;
    logic [IDX_W-1:0] w_fwd_age;
    logic [IDX_W-1:0] w_fwd_sel;
    logic             w_fwd_cover;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            // Age measured from head: larger means younger
            assign w_age[gi]      = IDX_W'(gi) - w_head_idx;
            assign w_fwd_cand[gi] = w_word_match[gi] && ((r_strb[gi] & ld_strb) != 4'h0);
        end
    endgenerate

    // Pick the youngest overlapping store
    always_comb begin
        w_fwd_found = 1'b0;
        w_fwd_age   = '0;
        w_fwd_sel   = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (w_fwd_cand[s] && (!w_fwd_found || (w_age[s] > w_fwd_age))) begin
                w_fwd_found = 1'b1;
                w_fwd_age   = w_age[s];
                w_fwd_sel   = IDX_W'(s);
            end
        end
    end

    assign w_fwd_cover = ((r_strb[w_fwd_sel] & ld_strb) == ld_strb);
    assign fwd_hit     = ld_valid && w_fwd_found && w_fwd_cover;
    assign fwd_stall   = ld_valid && w_fwd_found && !w_fwd_cover;
    assign fwd_data    = fwd_hit ? r_data[w_fwd_sel] : 32'h0;
`else
    assign fwd_hit   = 1'b0;
    assign fwd_data  = 32'h0;
    assign fwd_stall = ld_valid && (|w_word_match);
`endif

    // Byte offset of the load address never participates in matching
    assign w_unused_bits = ^{ld_addr[1:0], ld_strb};

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH     = 4;
    localparam int ROB_IDX_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid;
    logic [2:0]  alloc_rob_idx;
    logic        alloc_ready;
    logic [1:0]  alloc_sb_idx;
    logic        ex_valid;
    logic [1:0]  ex_sb_idx;
    logic [31:0] ex_addr;
    logic [31:0] ex_data;
    logic [3:0]  ex_strb;
    logic        st_commit;
    logic        mispredict;
    logic [7:0]  flush_mask;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_strb;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.DEPTH(DEPTH), .ROB_IDX_W(ROB_IDX_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rob_idx(alloc_rob_idx),
        .alloc_ready(alloc_ready), .alloc_sb_idx(alloc_sb_idx),
        .ex_valid(ex_valid), .ex_sb_idx(ex_sb_idx), .ex_addr(ex_addr),
        .ex_data(ex_data), .ex_strb(ex_strb),
        .st_commit(st_commit), .mispredict(mispredict), .flush_mask(flush_mask),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_strb(ld_strb),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        alloc_valid = 0; alloc_rob_idx = 0;
        ex_valid = 0; ex_sb_idx = 0; ex_addr = 0; ex_data = 0; ex_strb = 0;
        st_commit = 0; mispredict = 0; flush_mask = 0; mem_ack = 0;
        ld_valid = 0; ld_addr = 0; ld_strb = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic alloc(input logic [2:0] rob);
        alloc_valid = 1; alloc_rob_idx = rob;
        tick();
        alloc_valid = 0;
        $display("alloc rob=%0d", rob);
    endtask

    task automatic execute(input logic [1:0] idx, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        ex_valid = 1; ex_sb_idx = idx; ex_addr = a; ex_data = d; ex_strb = s;
        tick();
        ex_valid = 0;
        $display("exec slot=%0d addr=%h data=%h strb=%h", idx, a, d, s);
    endtask

    task automatic commit();
        st_commit = 1;
        tick();
        st_commit = 0;
        $display("commit");
    endtask

    task automatic test_reset();
        do_reset();
        $display("reset");
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
        checks++; if (alloc_sb_idx !== 2'd0) begin failures++; $display("FAIL reset_alloc_sb_idx got=%0d exp=0", alloc_sb_idx); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if ({mem_req, mem_addr, mem_wdata, mem_strb} !== 69'h0) begin failures++; $display("FAIL reset_mem got req=%b addr=%h wdata=%h strb=%h exp=0", mem_req, mem_addr, mem_wdata, mem_strb); end
        checks++; if ({fwd_hit, fwd_data, fwd_stall} !== 34'h0) begin failures++; $display("FAIL reset_fwd got hit=%b data=%h stall=%b exp=0", fwd_hit, fwd_data, fwd_stall); end
    endtask

    task automatic test_basic();
        do_reset();
        alloc(3'd2);
        execute(2'd0, 32'h100, 32'hDEADBEEF, 4'hF);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL basic_req_before_commit got=%b exp=0", mem_req); end
        mem_ack = 1;
        commit();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL basic_req_after_commit got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL basic_addr got=%h exp=00000100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_wdata got=%h exp=deadbeef", mem_wdata); end
        tick();
        mem_ack = 0;
        $display("drain");
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL basic_req_after_drain got=%b exp=0", mem_req); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(3'(i));
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_alloc_ready got=%b exp=0", alloc_ready); end
        alloc(3'd7);
        execute(2'd0, 32'h10, 32'h11, 4'hF);
        commit();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL full_req got=%b exp=1", mem_req); end
        // Drain while full with a concurrent alloc request: no bypass
        mem_ack = 1; alloc_valid = 1; alloc_rob_idx = 3'd6;
        tick();
        mem_ack = 0; alloc_valid = 0;
        $display("drain with alloc request");
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_drain got=%b exp=1", alloc_ready); end
        checks++; if (alloc_sb_idx !== 2'd0) begin failures++; $display("FAIL full_sb_idx_wrap got=%0d exp=0", alloc_sb_idx); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_next_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc(3'd1);
        alloc(3'd2);
        alloc(3'd3);
        execute(2'd0, 32'h300, 32'h11112222, 4'hF);
        st_commit = 1; mispredict = 1; flush_mask = 8'h08;
        tick();
        st_commit = 0; mispredict = 0; flush_mask = 0;
        $display("commit + mispredict mask=08");
        checks++; if (alloc_sb_idx !== 2'd2) begin failures++; $display("FAIL flush_tail got=%0d exp=2", alloc_sb_idx); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL flush_rob1_req got req=%b addr=%h exp req=1 addr=00000300", mem_req, mem_addr); end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        $display("drain rob1");
        checks++; if (mem_req !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL flush_after_drain got req=%b empty=%b exp req=0 empty=0", mem_req, empty); end
        execute(2'd1, 32'h304, 32'hA5A5A5A5, 4'hF);
        commit();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin failures++; $display("FAIL flush_rob2_req got req=%b addr=%h exp req=1 addr=00000304", mem_req, mem_addr); end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        $display("drain rob2");
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_rob3_gone got empty=%b exp=1", empty); end
        // Allocation is suppressed during a mispredict even with no squash match
        alloc_valid = 1; alloc_rob_idx = 3'd4; mispredict = 1; flush_mask = 8'h00;
        tick();
        alloc_valid = 0; mispredict = 0;
        $display("alloc during mispredict");
        checks++; if (alloc_sb_idx !== 2'd2 || empty !== 1'b1) begin failures++; $display("FAIL flush_alloc_suppressed got idx=%0d empty=%b exp idx=2 empty=1", alloc_sb_idx, empty); end
    endtask

    task automatic test_hold();
        do_reset();
        alloc(3'd5);
        execute(2'd0, 32'h400, 32'hCAFEF00D, 4'h5);
        alloc(3'd6);
        execute(2'd1, 32'h404, 32'h12345678, 4'hF);
        commit();
        commit();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'hCAFEF00D || mem_strb !== 4'h5) begin
                failures++;
                $display("FAIL hold_cycle%0d got req=%b addr=%h wdata=%h strb=%h exp req=1 addr=00000400 wdata=cafef00d strb=5",
                         c, mem_req, mem_addr, mem_wdata, mem_strb);
            end
            tick();
        end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        $display("ack after stall");
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h404 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL hold_one_pop got req=%b addr=%h wdata=%h exp req=1 addr=00000404 wdata=12345678", mem_req, mem_addr, mem_wdata); end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL hold_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forward();
        logic exp_hit, exp_stall;
        logic [31:0] exp_data;
        do_reset();
        alloc(3'd0);
        execute(2'd0, 32'h200, 32'h0000ABCD, 4'h3);
        alloc(3'd1);
        ld_valid = 1; ld_addr = 32'h200; ld_strb = 4'h3; #1;
`ifdef STORE_FWD_EN
        exp_hit = 1; exp_stall = 0; exp_data = 32'h0000ABCD;
`else
        exp_hit = 0; exp_stall = 1; exp_data = 32'h0;
`endif
        $display("load addr=200 strb=3");
        checks++; if (fwd_hit !== exp_hit || fwd_stall !== exp_stall || fwd_data !== exp_data) begin failures++; $display("FAIL fwd_cover got hit=%b stall=%b data=%h exp hit=%b stall=%b data=%h", fwd_hit, fwd_stall, fwd_data, exp_hit, exp_stall, exp_data); end
        ld_strb = 4'hF; #1;
        $display("load addr=200 strb=F");
        checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b1) begin failures++; $display("FAIL fwd_partial got hit=%b stall=%b exp hit=0 stall=1", fwd_hit, fwd_stall); end
        ld_strb = 4'hC; #1;
`ifdef STORE_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        $display("load addr=200 strb=C");
        checks++; if (fwd_hit !== 1'b0 || fwd_stall !== exp_stall) begin failures++; $display("FAIL fwd_no_overlap got hit=%b stall=%b exp hit=0 stall=%b", fwd_hit, fwd_stall, exp_stall); end
        ld_addr = 32'h204; ld_strb = 4'h3; #1;
        $display("load addr=204 strb=3");
        checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0 || fwd_data !== 32'h0) begin failures++; $display("FAIL fwd_miss got hit=%b stall=%b data=%h exp 0 0 0", fwd_hit, fwd_stall, fwd_data); end
        ld_valid = 0;
        execute(2'd1, 32'h200, 32'h00001234, 4'h3);
        ld_valid = 1; ld_addr = 32'h202; ld_strb = 4'h3; #1;
`ifdef STORE_FWD_EN
        exp_hit = 1; exp_stall = 0; exp_data = 32'h00001234;
`else
        exp_hit = 0; exp_stall = 1; exp_data = 32'h0;
`endif
        $display("load addr=202 strb=3 two stores");
        checks++; if (fwd_hit !== exp_hit || fwd_stall !== exp_stall || fwd_data !== exp_data) begin failures++; $display("FAIL fwd_youngest got hit=%b stall=%b data=%h exp hit=%b stall=%b data=%h", fwd_hit, fwd_stall, fwd_data, exp_hit, exp_stall, exp_data); end
        ld_valid = 0; #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin failures++; $display("FAIL fwd_idle got hit=%b stall=%b exp 0 0", fwd_hit, fwd_stall); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc(3'd4);
        execute(2'd0, 32'h500, 32'h55, 4'hF);
        commit();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL areset_pre_req got=%b exp=1", mem_req); end
        rst = 1;
        #1;
        $display("async reset mid-request");
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_strb !== 4'h0) begin failures++; $display("FAIL areset_mem got req=%b addr=%h wdata=%h strb=%h exp 0", mem_req, mem_addr, mem_wdata, mem_strb); end
        checks++; if (alloc_ready !== 1'b1 || alloc_sb_idx !== 2'd0 || empty !== 1'b1) begin failures++; $display("FAIL areset_ptrs got ready=%b idx=%0d empty=%b exp 1 0 1", alloc_ready, alloc_sb_idx, empty); end
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_hold();
        test_forward();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

In-order store buffer between dispatch/LSU execute and data memory, downstream of the ROB commit port. Stores get a slot at dispatch in program order and receive address/data at execute. They are marked committed when the ROB pulses `st_commit`, then drained to memory in order through a req/ack handshake. Uncommitted stores are discarded on mispredict using the ROB's `flush_mask`.

## Interface
- `DEPTH`, 4 — slot count; power of two, 2..16.
- `ROB_IDX_W`, 3 — ROB index width; `flush_mask` is 2**ROB_IDX_W bits.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset; one clock, reset is asynchronous and active-high.
- `alloc_valid` in 1 — dispatch of a store this cycle.
- `alloc_rob_idx` in ROB_IDX_W — ROB slot of the dispatched store.
- `alloc_ready` out 1 — buffer not full.
- `alloc_sb_idx` out log2(DEPTH) — slot that the next allocation takes (tail).
- `ex_valid` in 1 — LSU delivers store operands.
- `ex_sb_idx` in log2(DEPTH) — target slot.
- `ex_addr` in 32 — byte address.
- `ex_data` in 32 — store data, already lane-aligned.
- `ex_strb` in 4 — byte enables.
- `st_commit` in 1 — ROB commits the oldest uncommitted store.
- `mispredict` in 1 — flush request.
- `flush_mask` in 2**ROB_IDX_W — bit i set means ROB slot i is squashed.
- `mem_req` out 1 — drain request.
- `mem_addr` out 32 — drain address.
- `mem_wdata` out 32 — drain data.
- `mem_strb` out 4 — drain byte enables.
- `mem_ack` in 1 — memory accepted the request.
- `ld_valid` in 1 — forwarding lookup.
- `ld_addr` in 32 — lookup address.
- `ld_strb` in 4 — lookup byte enables.
- `fwd_hit` out 1 — lookup fully served.
- `fwd_data` out 32 — forwarded data.
- `fwd_stall` out 1 — load must retry.
- `empty` out 1 — no valid slots.

## Operation
- Per-slot state: `valid`, `executed`, `committed`, `rob_idx`, `addr`, `data`, `strb`.
- Pointers, each log2(DEPTH)+1 bits with a wrap bit:
  - `head`: oldest slot.
  - `cptr`: oldest uncommitted slot.
  - `tail`: next free slot.
- Invariant: head ≤ cptr ≤ tail in modular order.
- Full: low bits equal and wrap bits differ. Empty: head == tail.
- Alloc: if `alloc_valid && alloc_ready && !mispredict`, write slot[tail] with valid=1, executed=0, committed=0 and `rob_idx`; tail+1.
- Execute: if `ex_valid` and slot[ex_sb_idx] is valid, write addr/data/strb and set executed=1. Writes to an invalid slot are dropped.
- Commit: if `st_commit` and cptr≠tail, set slot[cptr].committed=1 and cptr+1. `st_commit` with cptr==tail is ignored.
- Drain:
  - `mem_req` = slot[head].valid && committed && executed.
  - `mem_*` come straight from slot[head].
  - On `mem_req && mem_ack`: clear slot[head], head+1.
- Flush: on `mispredict`, scan from cptr toward tail.
  - The first slot whose `flush_mask[rob_idx]` is set, and every slot after it, gets valid=0.
  - tail moves to that first slot. With no match, tail is unchanged.
  - Committed slots are never flushed.
- Simultaneous events, same cycle:
  - Commit is applied before the flush scan; the scan starts at cptr+1.
  - Drain always proceeds.
  - Execute to a slot being flushed is dropped.
  - Alloc is suppressed.
- Full and drain in the same cycle: `alloc_ready` stays 0; no bypass.

## Timing
- `alloc_ready`, `alloc_sb_idx`, `empty`, `mem_*`, `fwd_*` are combinational from registered state (plus `ld_*` for forwarding). All state updates on posedge `clk`.
- Alloc→execute: ex may arrive from the cycle after allocation.
- Commit→`mem_req`: 1 cycle minimum when the slot is at head.
- Drain throughput: one store per cycle with `mem_ack` held high.
- `mem_req` and `mem_*` stay stable until ack.
- Reset values, asynchronous:
  - all pointers 0, all slots cleared.
  - `alloc_ready`=1, `alloc_sb_idx`=0, `empty`=1.
  - `mem_req`=0, `mem_addr`/`mem_wdata`/`mem_strb`=0.
  - `fwd_hit`=0, `fwd_data`=0, `fwd_stall`=0.
- Reset asserted mid-handshake drops the pending request; memory must tolerate an unacked req disappearing.

## Configuration
- `STORE_FWD_EN` defined:
  - On `ld_valid`, search valid executed slots for `addr[31:2]==ld_addr[31:2]` with overlapping strb; the youngest match wins.
  - If the youngest match's strb covers `ld_strb`: `fwd_hit`=1, `fwd_data`=its data.
  - If it matches only partially: `fwd_stall`=1, `fwd_hit`=0.
- `STORE_FWD_EN` undefined:
  - `fwd_hit`=0 and `fwd_data`=0 always.
  - `fwd_stall`=1 whenever `ld_valid` and any valid executed slot has a word-address match.
- Ordering against unexecuted stores is the LSU's responsibility in both builds.

## Test plan
- Reset, then alloc rob 2, ex addr 0x100 data 0xDEADBEEF strb 0xF, `st_commit`, `mem_ack`=1 → `mem_req` one cycle after commit with addr 0x100 and wdata 0xDEADBEEF; `empty`=1 afterward.
- Alloc 4 stores → `alloc_ready`=0 and a 5th alloc is ignored. Commit one and drain it → `alloc_ready`=1 and `alloc_sb_idx`=0 (wrap).
- Alloc rob 1,2,3; commit rob 1; mispredict with flush_mask=0x08 → rob 3 slot invalid, tail at slot 2; rob 1 still drains.
- `mem_ack`=0 for 5 cycles → `mem_req`/`mem_addr` held constant; ack on cycle 6 pops exactly one slot.
- With `STORE_FWD_EN`: executed store 0x200 strb 0x3 data 0x0000ABCD.
  - Load strb 0x3 → `fwd_hit`=1, `fwd_data`[15:0]=0xABCD.
  - Load strb 0xF → `fwd_stall`=1.
  - Without the macro, the strb 0x3 load → `fwd_stall`=1, `fwd_hit`=0.
- Assert `rst` while `mem_req`=1 → all outputs at reset values immediately, without waiting for a clock edge.
